shift_pipe: RTL and testbench
=============================

// Module: shift_pipe
// PURPOSE
//  Parametrised, two-stage pipelined barrel shifter for the 32-bit processor datapath.
//  It adds ROR/ROL to SLL/SRL/SRA and uses a valid/ready handshake with backpressure.
//  Flags are fully defined (no x), including a true carry-out.
//  It sits between operand fetch and writeback as the ALU's shift execution unit.
// PARAMETERS
//  WIDTH  32  data width; power of 2, >= 8
//  SHW    5   shift-amount width; must equal $clog2(WIDTH)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  reset      in   1      asynchronous, active-high; clears all pipeline state
//  in_valid   in   1      din/func/shft_amnt valid this cycle
//  in_ready   out  1      unit accepts input this cycle
//  din        in   WIDTH  operand
//  func       in   5      op: 0C SLL, 0D SRL, 0E SRA, 0F ROR, 10 ROL; else pass-through
//  shft_amnt  in   SHW    shift/rotate amount, 0..WIDTH-1
//  out_valid  out  1      dout/flags valid
//  out_ready  in   1      consumer accepts output this cycle
//  dout       out  WIDTH  result
//  c, v, n, z out  1      carry, overflow, negative, zero flags for dout
// BEHAVIOUR
//  Reset: s1_valid=0, s2_valid=0. Outputs: out_valid=0, dout=0, c=v=n=0, z=1. In-flight ops are dropped.
//  Stage 1 register: captures din, func, shft_amnt[SHW-1:SHW/2+...] applied. It performs the upper
//   shift levels (amount bits SHW-1..SHW/2; for SHW=5, bits 4..3 = shift by 16, 8) plus carry tracking.
//  Stage 2 register (output): applies the remaining lower levels (bits 2..0) and computes flags.
//  Latency: 2 cycles from in_valid&&in_ready to out_valid with out_ready held high.
//  Throughput: 1 op/cycle.
//  Handshake:
//   - in_ready = !s1_valid || s2_adv; s2_adv = !out_valid || out_ready (combinational).
//   - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
//   - When stalled (out_valid && !out_ready), dout/flags/out_valid hold stable.
//     Stage 1 holds; in_ready=0 once s1 is full.
//   - Simultaneous in-accept and out-drain while both stages are full: both stages advance;
//     no bubble, no loss.
//  Arithmetic:
//   - SLL fills zeros at LSB. SRL fills zeros at MSB.
//   - SRA fills with din[WIDTH-1] (amount 31 on 32 bits -> all sign bits).
//   - ROR/ROL rotate modulo WIDTH.
//   - Amount 0: dout=din for every op.
//   - Unknown func: dout=din, c=0.
//  Flags:
//   - n=dout[WIDTH-1]; z=(dout==0).
//   - c: SLL -> din[WIDTH-amt]; SRL/SRA -> din[amt-1]; ROR -> dout[WIDTH-1]; ROL -> dout[0].
//   - c=0 when amt=0 or on pass-through.
//   - v=0 always, except SLL, where v=1 if any bit shifted out, or the new MSB, differs from
//     the original din[WIDTH-1] (signed overflow).
//  Reset asserted mid-operation: valids clear immediately, regardless of out_ready.
//   After reset deassert, the first accepted op appears 2 cycles later.
// TESTING
//  1. SRA din=32'h8000_0000 amt=31, out_ready=1 -> dout=FFFF_FFFF, n=1, z=0, c=0, v=0,
//     out_valid 2 cycles after accept.
//  2. SLL din=32'h4000_0001 amt=1 -> dout=8000_0002, c=0, v=1, n=1.
//     SRL din=3 amt=1 -> dout=1, c=1.
//  3. ROR din=32'h0000_0001 amt=1 -> dout=8000_0000, c=1.
//     ROL din=32'h8000_0000 amt=4 -> dout=0000_0008, c=0.
//     Then amt=0 on each op -> dout=din, c=0.
//  4. Back-to-back 8 ops with out_ready=1 -> 8 results in order on consecutive cycles.
//     Then out_ready=0 for 3 cycles -> dout held, in_ready=0 after 2 accepts, no loss/duplication.
//  5. Assert reset with both stages full -> out_valid=0, dout=0, z=1 same cycle.
//     Deassert, issue SRL din=F0 amt=4 -> dout=F after 2 cycles.
//  6. WIDTH=16, SHW=4: SRA din=16'h8001 amt=15 -> dout=FFFF, c=0.
//     Unknown func 5'h1F -> dout=din, c=0, v=0.

Source files
------------

// File: rtl/shift_pipe.sv
// Two-stage pipelined barrel shifter (SLL/SRL/SRA/ROR/ROL) with valid/ready flow control.
// Stage 1 applies the upper shift levels and resolves carry/overflow; stage 2 finishes the shift and sets n/z.
module shift_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [4:0]       func,
  input  logic [SHW-1:0]   shft_amnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             c,
  output logic             v,
  output logic             n,
  output logic             z
);

  localparam logic [4:0] OP_SLL = 5'h0C;
  localparam logic [4:0] OP_SRL = 5'h0D;
  localparam logic [4:0] OP_SRA = 5'h0E;
  localparam logic [4:0] OP_ROR = 5'h0F;
  localparam logic [4:0] OP_ROL = 5'h10;
  // Amount bits [SHW-1:LO] are applied in stage 1, bits [LO-1:0] in stage 2.
  localparam int LO = (SHW + 1) / 2;

  // Every op composes: shifting by hi then by lo equals shifting by hi+lo.
  function automatic logic [WIDTH-1:0] shift_op(input logic [4:0] op,
                                                input logic [WIDTH-1:0] d,
                                                input logic [SHW-1:0] a);
    logic signed [WIDTH-1:0] sd;
    logic [2*WIDTH-1:0]      dd;
    sd = d;
    dd = '0;
    shift_op = d;
    case (op)
      OP_SLL: shift_op = d << a;
      OP_SRL: shift_op = d >> a;
      OP_SRA: shift_op = sd >>> a;
      OP_ROR: begin
        dd = {d, d} >> a;
        shift_op = dd[WIDTH-1:0];
      end
      OP_ROL: begin
        dd = {d, d} << a;
        shift_op = dd[2*WIDTH-1:WIDTH];
      end
      default: shift_op = d;
    endcase
  endfunction

  // Last bit shifted out; for rotates this is the bit that wrapped into the result edge.
  function automatic logic carry_of(input logic [4:0] op,
                                    input logic [WIDTH-1:0] d,
                                    input logic [SHW-1:0] a);
    logic [SHW-1:0] lo_idx;
    logic [SHW-1:0] hi_idx;
    lo_idx = a - SHW'(1);
    hi_idx = '0 - a;
    carry_of = 1'b0;
    if (a != '0) begin
      case (op)
        OP_SRL, OP_SRA, OP_ROR: carry_of = d[lo_idx];
        OP_SLL, OP_ROL:         carry_of = d[hi_idx];
        default:                carry_of = 1'b0;
      endcase
    end
  endfunction

  // Signed overflow of a left shift: sign-extending the result back must reproduce din.
  function automatic logic sll_ovf(input logic [WIDTH-1:0] d,
                                   input logic [SHW-1:0] a);
    logic signed [WIDTH-1:0] sh;
    logic signed [WIDTH-1:0] back;
    sh   = d << a;
    back = sh >>> a;
    sll_ovf = (back != $signed(d));
  endfunction

  logic             s2_adv;
  logic [SHW-1:0]   amt_hi;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] shifted;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [4:0]       func_p1;
  logic [LO-1:0]    amt_lo_p1;
  logic             c_p1;
  logic             v_p1;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !vld_p1 || s2_adv;

  assign amt_hi = {shft_amnt[SHW-1:LO], {LO{1'b0}}};
  assign part   = shift_op(func, din, amt_hi);

  // ---- stage 1: upper shift levels, carry and overflow ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      func_p1   <= '0;
      amt_lo_p1 <= '0;
      c_p1      <= 1'b0;
      v_p1      <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        data_p1   <= part;
        func_p1   <= func;
        amt_lo_p1 <= shft_amnt[LO-1:0];
        c_p1      <= carry_of(func, din, shft_amnt);
        v_p1      <= (func == OP_SLL) && sll_ovf(din, shft_amnt);
      end
    end
  end

  assign shifted = shift_op(func_p1, data_p1, {{(SHW-LO){1'b0}}, amt_lo_p1});

  // ---- stage 2: lower shift levels, n/z, output register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      c         <= 1'b0;
      v         <= 1'b0;
      n         <= 1'b0;
      z         <= 1'b1;
    end else if (s2_adv) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        dout <= shifted;
        c    <= c_p1;
        v    <= v_p1;
        n    <= shifted[WIDTH-1];
        z    <= (shifted == '0);
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed, table-driven bench for shift_pipe: 32-bit and 16-bit instances plus
// hand-written handshake, stall and reset sequences.
module tb_shift_pipe;

  localparam logic [4:0] OP_SLL = 5'h0C;
  localparam logic [4:0] OP_SRL = 5'h0D;
  localparam logic [4:0] OP_SRA = 5'h0E;
  localparam logic [4:0] OP_ROR = 5'h0F;
  localparam logic [4:0] OP_ROL = 5'h10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] din, dout;
  logic [4:0]  func, amt;
  logic        c, v, n, z;

  logic        in_valid_h, in_ready_h, out_valid_h, out_ready_h;
  logic [15:0] din_h, dout_h;
  logic [4:0]  func_h;
  logic [3:0]  amt_h;
  logic        c_h, v_h, n_h, z_h;

  int total = 0;
  int bad   = 0;

  shift_pipe #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .func(func), .shft_amnt(amt), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .c(c), .v(v), .n(n), .z(z)
  );

  shift_pipe #(.WIDTH(16), .SHW(4)) dut16 (
    .clk(clk), .reset(rst), .in_valid(in_valid_h), .in_ready(in_ready_h),
    .din(din_h), .func(func_h), .shft_amnt(amt_h), .out_valid(out_valid_h),
    .out_ready(out_ready_h), .dout(dout_h), .c(c_h), .v(v_h), .n(n_h), .z(z_h)
  );

  typedef struct {
    logic [4:0]  f;
    logic [31:0] d;
    logic [4:0]  a;
    logic [31:0] q;
    logic [3:0]  cvnz;
  } vec_t;

  vec_t vt[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [4:0] f, input logic [31:0] d,
                        input logic [4:0] a, input logic [31:0] q, input logic [3:0] fl);
    check1({name, ":rdy"}, in_ready, 1'b1);
    in_valid = 1'b1; func = f; din = d; amt = a;
    step();
    in_valid = 1'b0;
    check1({name, ":early"}, out_valid, 1'b0);
    step();
    check1({name, ":vld"}, out_valid, 1'b1);
    check({name, ":dout"}, dout, q);
    check({name, ":cvnz"}, {28'h0, c, v, n, z}, {28'h0, fl});
  endtask

  task automatic run_op16(input string name, input logic [4:0] f, input logic [15:0] d,
                          input logic [3:0] a, input logic [15:0] q, input logic [3:0] fl);
    in_valid_h = 1'b1; func_h = f; din_h = d; amt_h = a;
    step();
    in_valid_h = 1'b0;
    check1({name, ":early"}, out_valid_h, 1'b0);
    step();
    check1({name, ":vld"}, out_valid_h, 1'b1);
    check({name, ":dout"}, {16'h0, dout_h}, {16'h0, q});
    check({name, ":cvnz"}, {28'h0, c_h, v_h, n_h, z_h}, {28'h0, fl});
  endtask

  initial begin
    // flags packed as {c, v, n, z}
    vt[0]  = '{OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 4'b0010};
    vt[1]  = '{OP_SLL, 32'h4000_0001, 5'd1,  32'h8000_0002, 4'b0110};
    vt[2]  = '{OP_SRL, 32'h0000_0003, 5'd1,  32'h0000_0001, 4'b1000};
    vt[3]  = '{OP_ROR, 32'h0000_0001, 5'd1,  32'h8000_0000, 4'b1010};
    vt[4]  = '{OP_ROL, 32'h8000_0000, 5'd4,  32'h0000_0008, 4'b0000};
    vt[5]  = '{OP_SLL, 32'h0000_1234, 5'd0,  32'h0000_1234, 4'b0000};
    vt[6]  = '{OP_SRL, 32'h8000_0001, 5'd0,  32'h8000_0001, 4'b0010};
    vt[7]  = '{OP_SRA, 32'h0000_00F0, 5'd0,  32'h0000_00F0, 4'b0000};
    vt[8]  = '{OP_ROR, 32'h0000_ABCD, 5'd0,  32'h0000_ABCD, 4'b0000};
    vt[9]  = '{OP_ROL, 32'h0000_0008, 5'd0,  32'h0000_0008, 4'b0000};
    vt[10] = '{5'h00,  32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 4'b0010};
    vt[11] = '{OP_SLL, 32'h8000_0000, 5'd1,  32'h0000_0000, 4'b1101};
    vt[12] = '{OP_SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 4'b1001};
    vt[13] = '{OP_ROL, 32'h1234_5678, 5'd8,  32'h3456_7812, 4'b0000};
    vt[14] = '{OP_ROR, 32'h1234_5678, 5'd4,  32'h8123_4567, 4'b1010};
    vt[15] = '{OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 4'b0110};
    vt[16] = '{OP_SLL, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFF0, 4'b1010};
    vt[17] = '{OP_SRL, 32'hFFFF_0000, 5'd16, 32'h0000_FFFF, 4'b0000};
    vt[18] = '{OP_SRA, 32'h8000_0000, 5'd17, 32'hFFFF_C000, 4'b0010};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; din = '0; func = '0; amt = '0;
    in_valid_h = 1'b0; out_ready_h = 1'b1; din_h = '0; func_h = '0; amt_h = '0;
    step();
    step();
    check1("rst_vld", out_valid, 1'b0);
    check("rst_dout", dout, 32'h0);
    check("rst_cvnz", {28'h0, c, v, n, z}, 32'h1);
    check1("rst_rdy", in_ready, 1'b1);
    rst = 1'b0;
    step();

    for (int i = 0; i < 19; i++)
      run_op($sformatf("vec%0d", i), vt[i].f, vt[i].d, vt[i].a, vt[i].q, vt[i].cvnz);

    run_op16("w16_sra", OP_SRA, 16'h8001, 4'd15, 16'hFFFF, 4'b0010);
    run_op16("w16_unk", 5'h1F,  16'h1234, 4'd3,  16'h1234, 4'b0000);
    run_op16("w16_rol", OP_ROL, 16'h8001, 4'd1,  16'h0003, 4'b1000);
    run_op16("w16_sll", OP_SLL, 16'h4000, 4'd1,  16'h8000, 4'b0110);
    step();

    // back-to-back: results on 8 consecutive cycles, in order
    begin
      int got;
      got = 0;
      for (int cyc = 0; cyc < 11; cyc++) begin
        if (cyc < 8) begin
          in_valid = 1'b1; func = OP_SLL; amt = 5'd1; din = 32'(cyc + 1);
          check1("b2b_rdy", in_ready, 1'b1);
        end else begin
          in_valid = 1'b0;
        end
        step();
        check1("b2b_vld", out_valid, (cyc >= 1) && (cyc <= 8));
        if (out_valid && got < 8) begin
          check("b2b_dout", dout, 32'((got + 1) * 2));
          got++;
        end
      end
      check("b2b_count", 32'(got), 32'd8);
    end

    // stall for 3 cycles, then drain while accepting with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; func = OP_SLL; amt = 5'd1; din = 32'h100;
    step();
    check1("st_vld0", out_valid, 1'b0);
    check1("st_rdy0", in_ready, 1'b1);
    din = 32'h200;
    step();
    check1("st_vld1", out_valid, 1'b1);
    check("st_dout1", dout, 32'h200);
    check1("st_rdy1", in_ready, 1'b0);
    din = 32'h300;
    step();
    check1("st_vld2", out_valid, 1'b1);
    check("st_dout2", dout, 32'h200);
    check1("st_rdy2", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    check1("st_rdy3", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check1("st_vld4", out_valid, 1'b1);
    check("st_dout4", dout, 32'h400);
    step();
    check1("st_vld5", out_valid, 1'b1);
    check("st_dout5", dout, 32'h600);
    step();
    check1("st_vld6", out_valid, 1'b0);

    // asynchronous reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; func = OP_SRL; amt = 5'd1; din = 32'h0000_0010;
    step();
    din = 32'h0000_0020;
    step();
    in_valid = 1'b0;
    check1("rf_full", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check1("rf_vld", out_valid, 1'b0);
    check("rf_dout", dout, 32'h0);
    check("rf_cvnz", {28'h0, c, v, n, z}, 32'h1);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    run_op("rf_srl", OP_SRL, 32'h0000_00F0, 5'd4, 32'h0000_000F, 4'b0000);
    step();
    check1("rf_drain", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
